// File: rtl/shift_mul_if.sv
// Request/response handshake bundle for shift_mul_sequencer.
// The master drives requests and consumes responses; the slave is the sequencer.
interface shift_mul_if #(
    parameter int unsigned TAG_WIDTH = 5
);
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_op;
    logic [31:0]          req_a;
    logic [31:0]          req_b;
    logic [TAG_WIDTH-1:0] req_tag;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_data;
    logic [TAG_WIDTH-1:0] resp_tag;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag
    );
endinterface

// File: rtl/shift_mul_sequencer.sv
// Iterative RV32M MUL/MULH/MULHSU/MULHU unit: one multiplier bit per cycle via shift_expander.
// Define SHIFT_MUL_EARLY_EXIT_EN to leave RUN once no multiplier bits remain above idx.
module shift_expander (
    input  logic [31:0] input_a,
    input  logic [6:0]  shift_index,
    output logic [63:0] expanded
);
    always_comb begin
        expanded = {32'd0, input_a} << shift_index;
    end
endmodule

module shift_mul_sequencer #(
    parameter int unsigned TAG_WIDTH = 5
) (
    input  logic        clk,
    input  logic        reset,
    shift_mul_if.slave  bus,
    input  logic        flush,
    output logic        busy
);
    typedef enum logic [1:0] {
        st_idle,
        st_run,
        st_fix,
        st_done
    } state_t;

    state_t               state_q;
    logic [31:0]          a_q;
    logic [31:0]          b_q;
    logic                 neg_q;
    logic [1:0]           op_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [63:0]          acc_q;
    logic [4:0]           idx_q;

    logic                 req_ready_q;
    logic                 resp_valid_q;
    logic                 busy_q;
    logic [31:0]          resp_data_q;
    logic [TAG_WIDTH-1:0] resp_tag_q;

    logic                 a_neg;
    logic                 b_neg;
    logic [31:0]          a_mag;
    logic [31:0]          b_mag;
    logic [63:0]          expanded;
    logic [63:0]          result;
    logic                 last_bit;

    // Only MULH/MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
    always_comb begin
        a_neg = ((bus.req_op == 2'b01) || (bus.req_op == 2'b10)) && bus.req_a[31];
        b_neg = (bus.req_op == 2'b01) && bus.req_b[31];
        a_mag = a_neg ? (~bus.req_a + 32'd1) : bus.req_a;
        b_mag = b_neg ? (~bus.req_b + 32'd1) : bus.req_b;
    end

    shift_expander u_expander (
        .input_a     (a_q),
        .shift_index ({2'b00, idx_q}),
        .expanded    (expanded)
    );

`ifdef SHIFT_MUL_EARLY_EXIT_EN
    logic [31:0] bits_above;

    always_comb begin
        bits_above = (b_q >> idx_q) >> 1;
        last_bit   = (idx_q == 5'd31) || (bits_above == 32'd0);
    end
`else
    always_comb begin
        last_bit = (idx_q == 5'd31);
    end
`endif

    always_comb begin
        result = neg_q ? (~acc_q + 64'd1) : acc_q;
    end

    // Flush shares the reset path so a killed op leaves no trace on the outputs.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q      <= st_idle;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            neg_q        <= 1'b0;
            op_q         <= 2'b00;
            tag_q        <= '0;
            acc_q        <= 64'd0;
            idx_q        <= 5'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_tag_q   <= '0;
        end else begin
            unique case (state_q)
                st_idle: begin
                    if (bus.req_valid) begin
                        a_q         <= a_mag;
                        b_q         <= b_mag;
                        neg_q       <= a_neg ^ b_neg;
                        op_q        <= bus.req_op;
                        tag_q       <= bus.req_tag;
                        acc_q       <= 64'd0;
                        idx_q       <= 5'd0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= st_run;
                    end
                end
                st_run: begin
                    if (b_q[idx_q]) begin
                        acc_q <= acc_q + expanded;
                    end
                    if (last_bit) begin
                        state_q <= st_fix;
                    end else begin
                        idx_q <= idx_q + 5'd1;
                    end
                end
                st_fix: begin
                    resp_data_q  <= (op_q == 2'b00) ? result[31:0] : result[63:32];
                    resp_tag_q   <= tag_q;
                    resp_valid_q <= 1'b1;
                    state_q      <= st_done;
                end
                st_done: begin
                    // req_ready rises only after this edge, so no same-cycle reaccept.
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= st_idle;
                    end
                end
                default: begin
                    state_q <= st_idle;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_tag   = resp_tag_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_shift_mul_sequencer.sv
// Self-checking bench for shift_mul_sequencer: vector table, scoreboard and corner sequences.
module tb_shift_mul_sequencer;
    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic busy;

    shift_mul_if #(.TAG_WIDTH(5)) bus ();

    shift_mul_sequencer #(.TAG_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .flush (flush),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
    } resp_t;

    resp_t sb_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [65:0] sa;
        logic signed [65:0] sb;
        logic signed [65:0] p;
        sa = ((op == 2'b01) || (op == 2'b10)) ? {{34{a[31]}}, a} : {34'd0, a};
        sb = (op == 2'b01) ? {{34{b[31]}}, b} : {34'd0, b};
        p  = sa * sb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int run_cycles(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] m;
        int          n;
        m = ((op == 2'b01) && b[31]) ? (~b + 32'd1) : b;
        n = 1;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) n = i + 1;
        end
`ifndef SHIFT_MUL_EARLY_EXIT_EN
        n = 32;
`endif
        return n;
    endfunction

    // Scoreboard: every completed handshake must match the oldest outstanding request.
    resp_t got;
    always @(negedge clk) begin
        if (!reset && bus.resp_valid && bus.resp_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got data 0x%0h tag %0d, expected no response",
                         bus.resp_data, bus.resp_tag);
            end else begin
                got = sb_q.pop_front();
                check("resp_data", {32'd0, bus.resp_data}, {32'd0, got.data});
                check("resp_tag", {59'd0, bus.resp_tag}, {59'd0, got.tag});
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp, input bit push);
        int cnt = 0;
        while (!bus.req_ready && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("req_ready_wait", {63'd0, bus.req_ready}, 64'd1);
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        bus.req_valid = 1'b1;
        @(posedge clk);
        if (push) sb_q.push_back('{data: exp, tag: tag});
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int cnt);
        cnt = 0;
        while (!bus.resp_valid && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("resp_valid_wait", {63'd0, bus.resp_valid}, 64'd1);
    endtask

    task automatic do_op(input vec_t v);
        int cnt;
        send(v.op, v.a, v.b, v.tag, v.exp, 1'b1);
        wait_resp(cnt);
        check("latency", cnt, run_cycles(v.op, v.b) + 1);
        @(posedge clk);
        #1;
        check("idle_busy", {63'd0, busy}, 64'd0);
        check("idle_req_ready", {63'd0, bus.req_ready}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog");
    end

    vec_t        vecs[12];
    vec_t        rv;
    int          cnt;
    logic [31:0] exp_bp;

    initial begin
        vecs[0]  = '{2'b00, 32'd7,         32'd6,         5'd3,  32'h0000002A};
        vecs[1]  = '{2'b11, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd17, 32'hFFFFFFFE};
        vecs[2]  = '{2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd1,  32'h00000001};
        vecs[3]  = '{2'b01, 32'h80000000,  32'h80000000,  5'd31, 32'h40000000};
        vecs[4]  = '{2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd8,  32'h00000000};
        vecs[5]  = '{2'b10, 32'hFFFFFFFE,  32'd3,         5'd22, 32'hFFFFFFFF};
        vecs[6]  = '{2'b00, 32'd9,         32'd0,         5'd4,  32'h00000000};
        vecs[7]  = '{2'b00, 32'd9,         32'h00000100,  5'd5,  32'h00000900};
        vecs[8]  = '{2'b01, 32'd0,         32'h80000000,  5'd9,  32'h00000000};
        vecs[9]  = '{2'b01, 32'hFFFFFFFD,  32'd5,         5'd10, 32'hFFFFFFFF};
        vecs[10] = '{2'b10, 32'd5,         32'hFFFFFFFF,  5'd11, 32'h00000004};
        vecs[11] = '{2'b00, 32'h80000000,  32'h80000000,  5'd12, 32'h00000000};

        reset          = 1'b1;
        flush          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b00;
        bus.req_a      = 32'd0;
        bus.req_b      = 32'd0;
        bus.req_tag    = 5'd0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_resp_data", {32'd0, bus.resp_data}, 64'd0);
        check("rst_resp_tag", {59'd0, bus.resp_tag}, 64'd0);

        for (int i = 0; i < 12; i++) do_op(vecs[i]);

        for (int i = 0; i < 6; i++) begin
            rv.op  = 2'($urandom_range(0, 3));
            rv.a   = $urandom;
            rv.b   = $urandom;
            rv.tag = 5'($urandom_range(0, 31));
            rv.exp = model(rv.op, rv.a, rv.b);
            do_op(rv);
        end

        // Backpressure: result must hold for 10 cycles with no new request accepted.
        bus.resp_ready = 1'b0;
        exp_bp = model(2'b11, 32'h12345678, 32'h9ABCDEF0);
        send(2'b11, 32'h12345678, 32'h9ABCDEF0, 5'd19, exp_bp, 1'b1);
        wait_resp(cnt);
        for (int i = 0; i < 10; i++) begin
            check("bp_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
            check("bp_resp_data", {32'd0, bus.resp_data}, {32'd0, exp_bp});
            check("bp_req_ready", {63'd0, bus.req_ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_busy", {63'd0, busy}, 64'd0);
        check("bp_release_valid", {63'd0, bus.resp_valid}, 64'd0);

        // Flush during RUN drops the op; the next op still completes.
        send(2'b00, 32'd5, 32'd5, 5'd6, 32'd25, 1'b1);
        repeat (11) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        sb_q.delete();
        #1;
        flush = 1'b0;
        check("flush_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_req_ready", {63'd0, bus.req_ready}, 64'd1);
        rv = '{2'b00, 32'd3, 32'd4, 5'd7, 32'h0000000C};
        do_op(rv);

        // Flush in IDLE with a pending request must not accept it.
        bus.req_op    = 2'b00;
        bus.req_a     = 32'd2;
        bus.req_b     = 32'd2;
        bus.req_tag   = 5'd2;
        bus.req_valid = 1'b1;
        flush         = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        flush         = 1'b0;
        check("idle_flush_busy", {63'd0, busy}, 64'd0);
        check("idle_flush_req_ready", {63'd0, bus.req_ready}, 64'd1);
        repeat (40) @(posedge clk);
        #1;
        check("idle_flush_no_resp", {63'd0, bus.resp_valid}, 64'd0);

        // Reset mid-operation clears everything, including the old resp_data.
        send(2'b00, 32'h1234, 32'h10, 5'd13, 32'h12340, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        sb_q.delete();
        #1;
        reset = 1'b0;
        check("midrst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        check("midrst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_resp_data", {32'd0, bus.resp_data}, 64'd0);
        check("midrst_resp_tag", {59'd0, bus.resp_tag}, 64'd0);

        rv = '{2'b11, 32'h0000FFFF, 32'h00010001, 5'd21, 32'h00000000};
        do_op(rv);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb_q.size(), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
